// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler driving an external 8:1 mux select
// Arbitrates eight requesters, samples the mux one cycle after select, presents result on valid/ready.
module mux8_rr_scheduler (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       mux_y,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       out_valid,
   output logic       out_data,
   output logic [2:0] out_chan,
   input  logic       out_ready
);
   localparam int N_CH = 8;

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_HOLD} state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_ptr;
   logic [2:0] r_sel;
   logic [7:0] r_gnt;
   logic       r_busy;
   logic       r_out_valid;
   logic       r_out_data;
   logic [2:0] r_out_chan;
   logic       w_any_req;
   logic [2:0] w_pick;
   logic       w_accept;

   assign w_any_req = |req;
   assign w_accept  = r_out_valid && out_ready;

   // Scan from the farthest offset down so the channel nearest r_ptr wins.
   always_comb begin
      w_pick = r_ptr;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[r_ptr + 3'(i)]) begin
            w_pick = r_ptr + 3'(i);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_state_next = S_SAMPLE;
         S_SAMPLE: w_state_next = S_HOLD;
         S_HOLD:   if (w_accept) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= 3'd0;
         r_sel       <= 3'd0;
         r_gnt       <= 8'd0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 1'b0;
         r_out_chan  <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_sel <= w_pick;
                  r_gnt <= 8'b1 << w_pick;
               end
            end
            S_SAMPLE: begin
               r_out_data  <= mux_y;
               r_out_chan  <= r_sel;
               r_out_valid <= 1'b1;
            end
            S_HOLD: begin
               // Served channel drops to lowest priority; 3-bit add wraps 7 to 0.
               if (w_accept) begin
                  r_out_valid <= 1'b0;
                  r_gnt       <= 8'd0;
                  r_ptr       <= r_sel + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sel       = r_sel;
   assign gnt       = r_gnt;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb/tb_mux8_rr_scheduler.sv - scoreboard bench for mux8_rr_scheduler
module tb_mux8_rr_scheduler;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       mux_y;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic       out_valid;
   logic       out_data;
   logic [2:0] out_chan;
   logic       out_ready;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] sb[$];

   mux8_rr_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .mux_y(mux_y), .sel(sel), .gnt(gnt),
      .busy(busy), .out_valid(out_valid), .out_data(out_data),
      .out_chan(out_chan), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted result must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_xfer: got chan %0d data %0b want none", out_chan, out_data);
         end else begin
            logic [3:0] e;
            e = sb.pop_front();
            chk("mon_chan", {5'd0, out_chan}, {5'd0, e[3:1]});
            chk("mon_data", {7'd0, out_data}, {7'd0, e[0]});
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; req = 8'd0; out_ready = 1'b0; mux_y = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] r, input logic m, input logic [2:0] ch, input bit hold_req);
      req = r; mux_y = m; out_ready = 1'b1;
      sb.push_back({ch, m});
      step();
      chk("gnt", gnt, 8'b1 << ch);
      chk("sel", {5'd0, sel}, {5'd0, ch});
      chk("busy_sample", {7'd0, busy}, 8'd1);
      chk("valid_sample", {7'd0, out_valid}, 8'd0);
      if (!hold_req) req = 8'd0;
      step();
      chk("valid_hold", {7'd0, out_valid}, 8'd1);
      step();
      chk("busy_idle", {7'd0, busy}, 8'd0);
      chk("valid_idle", {7'd0, out_valid}, 8'd0);
      chk("gnt_idle", gnt, 8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("rst_sel", {5'd0, sel}, 8'd0);
      chk("rst_gnt", gnt, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_data", {7'd0, out_data}, 8'd0);
      chk("rst_chan", {5'd0, out_chan}, 8'd0);

      // Single request on channel 5; sel holds in IDLE; ptr now 6 so 8'h61 picks 6.
      xfer(8'h20, 1'b1, 3'd5, 1'b0);
      chk("sel_kept", {5'd0, sel}, 8'd5);
      xfer(8'h61, 1'b0, 3'd6, 1'b0);

      // Round-robin with all requests held: 3-cycle cadence checked inside xfer.
      do_reset();
      for (int i = 0; i < 9; i++) xfer(8'hFF, i[0], 3'(i % 8), 1'b1);
      req = 8'd0;
      step(); step(); step();

      // Wrap-around: after 7, channel 0 outranks 7.
      do_reset();
      xfer(8'h80, 1'b1, 3'd7, 1'b0);
      xfer(8'h81, 1'b0, 3'd0, 1'b0);

      // Backpressure on channel 2 for five cycles.
      req = 8'h04; mux_y = 1'b1; out_ready = 1'b0;
      sb.push_back({3'd2, 1'b1});
      step();
      req = 8'd0;
      chk("bp_gnt", gnt, 8'h04);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_chan", {5'd0, out_chan}, 8'd2);
         chk("bp_sel", {5'd0, sel}, 8'd2);
         chk("bp_gnt_hold", gnt, 8'h04);
         chk("bp_busy", {7'd0, busy}, 8'd1);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_done_busy", {7'd0, busy}, 8'd0);
      chk("bp_done_valid", {7'd0, out_valid}, 8'd0);

      // Request withdrawn during SAMPLE still completes on channel 3.
      xfer(8'h08, 1'b1, 3'd3, 1'b0);

      // Reset in HOLD discards the result; ptr (4) must return to 0.
      req = 8'h20; mux_y = 1'b1; out_ready = 1'b0;
      step();
      req = 8'd0;
      step();
      chk("pre_rst_valid", {7'd0, out_valid}, 8'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_rst_gnt", gnt, 8'd0);
      chk("mid_rst_sel", {5'd0, sel}, 8'd0);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      rst = 1'b0;
      xfer(8'h12, 1'b0, 3'd1, 1'b0);

      step(); step();
      chk("sb_empty", 8'(sb.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
